// File: rtl/wave_pkg.sv
// Shared definitions for the waveform capture path: FSM states, default widths
// and the half-buffer depth of the sample RAM.
package wave_pkg;

    localparam int SAMPLE_W = 16;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 8;

    localparam int HALF_DEPTH = 2 ** (ADDR_W - 1);

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } wave_state_e;

endpackage

// File: rtl/wave_capture_ctrl_if.sv
// Bundle of the sample stream, display handshake and RAM-port signals seen by
// the capture controller; slave is the controller side.
interface wave_capture_ctrl_if #(
    parameter int SAMPLE_W = 16,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8
) ();

    logic                       new_sample;
    logic signed [SAMPLE_W-1:0] sample;
    logic                       display_idle;
    logic [ADDR_W-2:0]          read_index;
    logic                       ram_we;
    logic [ADDR_W-1:0]          ram_waddr;
    logic [DATA_W-1:0]          ram_wdata;
    logic [ADDR_W-1:0]          ram_raddr;
    logic [1:0]                 state;
    logic                       frame_done;

    modport slave (
        input  new_sample, sample, display_idle, read_index,
        output ram_we, ram_waddr, ram_wdata, ram_raddr, state, frame_done
    );

    modport master (
        output new_sample, sample, display_idle, read_index,
        input  ram_we, ram_waddr, ram_wdata, ram_raddr, state, frame_done
    );

endinterface

// File: rtl/zero_cross_detect.sv
// Rising zero-crossing detector: flags a non-negative sample that directly
// follows a negative one in the strobed sample stream.
module zero_cross_detect (
    input  logic clk,
    input  logic rst,
    input  logic new_sample_i,
    input  logic sample_msb_i,
    output logic trigger_o
);

    logic prev_neg_q;
    logic prev_neg_d;

    always_comb begin
        prev_neg_d = prev_neg_q;
        if (new_sample_i) begin
            prev_neg_d = sample_msb_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_neg_q <= 1'b0;
        end else begin
            prev_neg_q <= prev_neg_d;
        end
    end

    assign trigger_o = new_sample_i && prev_neg_q && !sample_msb_i;

endmodule

// File: rtl/wave_capture_ctrl.sv
// Triggered frame capture into one half of a ping-pong sample RAM while the
// display reads the other half; halves swap only while the display is idle.
module wave_capture_ctrl
    import wave_pkg::*;
#(
    parameter int SAMPLE_W = wave_pkg::SAMPLE_W,
    parameter int DATA_W   = wave_pkg::DATA_W,
    parameter int ADDR_W   = wave_pkg::ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    wave_capture_ctrl_if.slave bus
);

    localparam int IDX_W = ADDR_W - 1;
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    function automatic logic [DATA_W-1:0] to_offset_binary(
        input logic signed [SAMPLE_W-1:0] s
    );
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2 -: DATA_W-1]};
    endfunction

    wave_state_e       state_q, state_d;
    logic              wbuf_q, wbuf_d;
    logic [IDX_W-1:0]  count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              frame_done_q, frame_done_d;
    logic              trigger;

    zero_cross_detect u_zcd (
        .clk          (clk),
        .rst          (rst),
        .new_sample_i (bus.new_sample),
        .sample_msb_i (bus.sample[SAMPLE_W-1]),
        .trigger_o    (trigger)
    );

    // Write strobe is one cycle wide; address/data hold their last value between writes.
    always_comb begin
        state_d      = state_q;
        wbuf_d       = wbuf_q;
        count_d      = count_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        frame_done_d = 1'b0;

        case (state_q)
            ARMED: begin
                if (trigger) begin
                    we_d    = 1'b1;
                    waddr_d = {wbuf_q, IDX_ZERO};
                    wdata_d = to_offset_binary(bus.sample);
                    count_d = IDX_ONE;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (bus.new_sample) begin
                    we_d    = 1'b1;
                    waddr_d = {wbuf_q, count_q};
                    wdata_d = to_offset_binary(bus.sample);
                    count_d = count_q + IDX_ONE;
                    if (count_q == IDX_LAST) begin
                        frame_done_d = 1'b1;
                        state_d      = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.display_idle) begin
                    wbuf_d  = ~wbuf_q;
                    state_d = ARMED;
                end
            end
            default: begin
                state_d = ARMED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARMED;
            wbuf_q       <= 1'b0;
            count_q      <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wbuf_q       <= wbuf_d;
            count_q      <= count_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.ram_we     = we_q;
    assign bus.ram_waddr  = waddr_q;
    assign bus.ram_wdata  = wdata_q;
    assign bus.ram_raddr  = {~wbuf_q, bus.read_index};
    assign bus.state      = state_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Scoreboard bench for wave_capture_ctrl: expected RAM writes are queued as
// samples are driven and checked against each observed ram_we cycle.
module tb_wave_capture_ctrl;
    import wave_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [16:0] sb[$];

    wave_capture_ctrl_if #(.SAMPLE_W(16), .DATA_W(8), .ADDR_W(8)) bus ();

    wave_capture_ctrl #(.SAMPLE_W(16), .DATA_W(8), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_data(input logic [15:0] s);
        logic [15:0] t;
        t = s >> 8;
        return t[7:0] ^ 8'h80;
    endfunction

    always @(negedge clk) begin
        logic [16:0] e;
        if (bus.ram_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_we_addr", {24'h0, bus.ram_waddr}, 32'hDEAD);
            end else begin
                e = sb.pop_front();
                chk("waddr", {24'h0, bus.ram_waddr}, {24'h0, e[16:9]});
                chk("wdata", {24'h0, bus.ram_wdata}, {24'h0, e[8:1]});
                chk("frame_done", {31'h0, bus.frame_done}, {31'h0, e[0]});
            end
        end else if (bus.frame_done === 1'b1) begin
            chk("frame_done_without_we", {31'h0, bus.frame_done}, 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [15:0] s);
        bus.new_sample = 1'b1;
        bus.sample     = s;
        tick();
        bus.new_sample = 1'b0;
    endtask

    task automatic expect_strobe(input logic [7:0] addr, input logic [15:0] s, input logic fd);
        sb.push_back({addr, exp_data(s), fd});
        strobe(s);
    endtask

    task automatic fill_frame(input logic msb);
        logic [15:0] s;
        for (int i = 1; i < HALF_DEPTH; i++) begin
            s = 16'($urandom);
            expect_strobe({msb, 7'(i)}, s, i == HALF_DEPTH - 1);
        end
    endtask

    task automatic drain(input string tag);
        tick();
        tick();
        chk(tag, sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, {30'h0, bus.state}, 32'h0);
        chk({tag, "_we"}, {31'h0, bus.ram_we}, 32'h0);
        chk({tag, "_waddr"}, {24'h0, bus.ram_waddr}, 32'h0);
        chk({tag, "_wdata"}, {24'h0, bus.ram_wdata}, 32'h0);
        chk({tag, "_fd"}, {31'h0, bus.frame_done}, 32'h0);
        chk({tag, "_raddr"}, {24'h0, bus.ram_raddr}, {24'h0, 1'b1, bus.read_index});
    endtask

    initial begin
        bus.new_sample   = 1'b0;
        bus.sample       = '0;
        bus.display_idle = 1'b0;
        bus.read_index   = 7'h15;

        // Reset state
        tick();
        tick();
        check_reset_outputs("rst");
        chk("rst_raddr_const", {24'h0, bus.ram_raddr}, 32'h95);
        rst = 1'b0;
        tick();

        // First trigger: -5 then +3
        strobe(16'hFFFB);
        tick();
        expect_strobe(8'h00, 16'h0003, 1'b0);
        chk("t1_state_active", {30'h0, bus.state}, 32'd1);

        // Rest of frame back-to-back, display_idle must not swap mid-frame
        bus.display_idle = 1'b1;
        fill_frame(1'b0);
        bus.display_idle = 1'b0;
        chk("t2_state_wait", {30'h0, bus.state}, 32'd2);
        chk("t2_raddr_msb", {31'h0, bus.ram_raddr[7]}, 32'd1);
        drain("t2_drain");

        // WAIT: strobes ignored without display_idle
        for (int i = 0; i < 10; i++) begin
            strobe((i % 2 == 0) ? 16'h0100 : 16'hF000);
        end
        chk("t3_wait_raddr_msb", {31'h0, bus.ram_raddr[7]}, 32'd1);
        chk("t3_wait_state", {30'h0, bus.state}, 32'd2);
        bus.display_idle = 1'b1;
        tick();
        bus.display_idle = 1'b0;
        chk("t3_swap_raddr_msb", {31'h0, bus.ram_raddr[7]}, 32'd0);
        chk("t3_swap_state", {30'h0, bus.state}, 32'd0);
        expect_strobe(8'h80, 16'h7FFF, 1'b0);
        fill_frame(1'b1);
        chk("t3_state_wait", {30'h0, bus.state}, 32'd2);
        drain("t3_drain");
        bus.display_idle = 1'b1;
        tick();
        bus.display_idle = 1'b0;
        chk("t3_swap_back_raddr_msb", {31'h0, bus.ram_raddr[7]}, 32'd1);

        // Positive-only samples after reset never trigger
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            strobe(16'(i * 1000));
        end
        chk("t4_state_armed", {30'h0, bus.state}, 32'd0);
        drain("t4_drain");

        // Reset after 40 writes aborts the frame
        strobe(16'hFFFF);
        expect_strobe(8'h00, 16'h0064, 1'b0);
        for (int i = 1; i < 40; i++) begin
            expect_strobe(8'(i), 16'(i * 300 - 6000), 1'b0);
        end
        chk("t5_state_active", {30'h0, bus.state}, 32'd1);
        rst = 1'b1;
        tick();
        check_reset_outputs("t5_rst");
        bus.new_sample = 1'b1;
        bus.sample     = 16'hFFFF;
        tick();
        bus.new_sample = 1'b0;
        rst = 1'b0;
        strobe(16'h0005);
        chk("t5_rst_prio_state", {30'h0, bus.state}, 32'd0);
        strobe(16'hFFFE);
        expect_strobe(8'h00, 16'h0002, 1'b0);
        chk("t5_retrigger_state", {30'h0, bus.state}, 32'd1);

        // Complete that frame, then same-cycle strobe + display_idle in WAIT
        fill_frame(1'b0);
        drain("t5_drain");
        chk("t6_state_wait", {30'h0, bus.state}, 32'd2);
        bus.display_idle = 1'b1;
        strobe(16'hFFFF);
        bus.display_idle = 1'b0;
        chk("t6_swap_state", {30'h0, bus.state}, 32'd0);
        chk("t6_swap_raddr_msb", {31'h0, bus.ram_raddr[7]}, 32'd0);
        expect_strobe(8'h80, 16'h0001, 1'b0);
        chk("t6_state_active", {30'h0, bus.state}, 32'd1);
        drain("t6_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wave_capture_ctrl.md
# wave_capture_ctrl

Sequences writes into the shared `ram_1w2r` sample RAM: captures one triggered frame of audio samples per buffer, starting at a rising zero crossing. It sits between the audio sample stream and the waveform display. The RAM is split into two half-buffers; the controller writes one half and points the display read port at the other. It swaps halves only when the display reports it is idle, so a frame is never torn.

## Interface
- `SAMPLE_W`, 16: width of the signed input sample.
- `DATA_W`, 8: RAM word width; matches `ram_1w2r` data width.
- `ADDR_W`, 8: RAM address width. MSB selects the half-buffer; the lower `ADDR_W-1` bits are the sample index.

- `clk` in 1: sole clock; also drives RAM `clka`/`clkb`.
- `rst` in 1: synchronous, active-high reset.
- `new_sample` in 1: one-cycle strobe; `sample` is valid this cycle.
- `sample` in `SAMPLE_W`: signed two's-complement audio sample.
- `display_idle` in 1: high while the display is not reading, e.g. vblank.
- `read_index` in `ADDR_W-1`: display's requested sample index.
- `ram_we` out 1: drives RAM `wea`.
- `ram_waddr` out `ADDR_W`: drives RAM `addra`.
- `ram_wdata` out `DATA_W`: drives RAM `dina`.
- `ram_raddr` out `ADDR_W`: drives RAM `addrb`.
- `state` out 2: current FSM state, for debug.
- `frame_done` out 1: one-cycle pulse when a half-buffer fills.

## Operation
- State encodings: ARMED=0, ACTIVE=1, WAIT=2. Code 3 is unreachable and recovers to ARMED.
- `prev_neg` register: on every `new_sample` strobe, in any state, `prev_neg <= sample[SAMPLE_W-1]`.
- Trigger: `new_sample && prev_neg && !sample[SAMPLE_W-1]`.
- ARMED:
  - A strobe that is not a trigger writes nothing.
  - A trigger writes that sample at index 0, sets `count <= 1`, and goes to ACTIVE.
- ACTIVE:
  - Each strobe writes at index `count`, then increments `count`.
  - The write at index `2^(ADDR_W-1)-1` (127 by default) goes to WAIT and pulses `frame_done`.
- WAIT:
  - Strobes are ignored for writing; `prev_neg` still updates.
  - When `display_idle` is high, toggle `wbuf` and go to ARMED.
- Data conversion: `ram_wdata = {~sample[SAMPLE_W-1], sample[SAMPLE_W-2 -: DATA_W-1]}`, i.e. the top `DATA_W` bits in offset-binary form.
  - Example: `sample`=16'h8000 gives 8'h00; 16'h0000 gives 8'h80; 16'h7FFF gives 8'hFF.
- Write address: `ram_waddr = {wbuf, index}`.
- Read address: `ram_raddr = {~wbuf, read_index}`, combinational.

## Timing
- Reset values (cycle after `rst` sampled high):
  - State ARMED; `wbuf`=0; `count`=0; `prev_neg`=0.
  - `ram_we`=0, `ram_waddr`=0, `ram_wdata`=0, `frame_done`=0.
  - `ram_raddr` = {1, `read_index`}.
- Write signals are registered. A strobe accepted in cycle N gives `ram_we`=1 with valid addr/data in cycle N+1, for exactly one cycle.
- `frame_done` rises in the same cycle as the final `ram_we`.
- The state change takes effect at the same edge that registers the write.
- The `wbuf` toggle is visible on `ram_raddr` one cycle after `display_idle` is sampled in WAIT.
- `display_idle` is ignored in ARMED and ACTIVE; no swap mid-frame.
- `new_sample` and `display_idle` in the same WAIT cycle: swap happens, sample not written, `prev_neg` updated.
- Back-to-back strobes every cycle are supported; one write per cycle.
- `rst` mid-ACTIVE:
  - Capture aborts and `wbuf` returns to 0.
  - RAM contents are not cleared; the partial frame remains in RAM.
- `rst` takes priority over `new_sample` in the same cycle; no write, `prev_neg` stays 0.
- Because `prev_neg` resets to 0, a negative sample must be seen before the first trigger after reset.

## Structure
- Shared package `wave_pkg`:
  - State localparams ARMED, ACTIVE, WAIT.
  - Default `ADDR_W`/`DATA_W`/`SAMPLE_W`.
  - Half-buffer depth `HALF_DEPTH = 2**(ADDR_W-1)`.
- Natural sub-module `zero_cross_detect`:
  - Owns `prev_neg`; inputs `clk`, `rst`, `new_sample`, `sample` MSB.
  - Output is a one-cycle-valid `trigger`.
- The `ram_1w2r` instance lives in the parent; this block only drives its ports.

## Test plan
- Reset, then samples -5, +3 with strobes two cycles apart → one `ram_we` at `ram_waddr`=8'h00, `ram_wdata`=8'h80. State goes ARMED→ACTIVE.
- Trigger, then 127 further strobes, every cycle → 128 writes at addresses 0x00..0x7F in order. `frame_done` pulses once with the write to 0x7F; state=WAIT.
- In WAIT: 10 strobes with `display_idle`=0 → no `ram_we`, `ram_raddr` MSB stays 1. Then `display_idle`=1 for one cycle → next cycle `ram_raddr` MSB=0 and state=ARMED. The next frame writes 0x80..0xFF.
- Positive-only samples after reset (no negative ever seen) → state stays ARMED, `ram_we` never asserts.
- `rst` asserted after 40 writes of a frame → all outputs at reset values next cycle, `wbuf`=0. The next trigger writes at 0x00.
- Same-cycle `new_sample`(-1) and `display_idle` in WAIT → swap occurs, no write. A following strobe of +1 triggers a capture at index 0 of the new buffer.
